// File: rtl/cnu_minsum.sv
// Serial offset-min-sum check-node unit.
//
// Purpose: accepts one Z-lane V2C vector per cycle for each non-zero block
// column of a base-matrix row. It tracks per-lane min1/min2/argmin/sign state,
// then streams the C2V vectors back out in the same column order.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_last marks the final column of a row
//   in                  Z lanes of BITS-bit two's-complement messages, lane l at in[l]
//   out_valid/out_ready output handshake; out_last marks the final output of a row
//   out                 Z lanes of BITS-bit two's-complement C2V messages (registered)
module cnu_minsum #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned Z       = 7,
  parameter int unsigned DEG_MAX = 8,
  parameter int unsigned OFFSET  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [Z-1:0][BITS-1:0] in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [Z-1:0][BITS-1:0] out
);

  localparam int unsigned MW = BITS - 1;
  localparam int unsigned KW = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;
  localparam logic [MW-1:0] MaxMag = {MW{1'b1}};
  localparam logic [MW-1:0] Off    = MW'(OFFSET);
  localparam logic [KW-1:0] KLast  = KW'(DEG_MAX - 1);

  typedef enum logic [0:0] {StAcc, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            j_q, j_d;
  logic [KW-1:0]            last_q, last_d;  // row degree minus one
  logic [MW-1:0]            min1_q [Z];
  logic [MW-1:0]            min1_d [Z];
  logic [MW-1:0]            min2_q [Z];
  logic [MW-1:0]            min2_d [Z];
  logic [KW-1:0]            idx_q  [Z];
  logic [KW-1:0]            idx_d  [Z];
  logic [Z-1:0]             sgn_q, sgn_d;
  logic [Z-1:0]             smem_q [DEG_MAX];
  logic [Z-1:0]             smem_d [DEG_MAX];
  logic [Z-1:0][BITS-1:0]   out_q, out_d;
  logic                     olast_q, olast_d;

  // |v| with the most negative code saturated to the largest magnitude.
  function automatic logic [MW-1:0] mag_of(input logic [BITS-1:0] v);
    logic [BITS-1:0] n;
    n = -v;
    if (!v[BITS-1])          return v[MW-1:0];
    else if (v[MW-1:0] == '0) return MaxMag;
    else                     return n[MW-1:0];
  endfunction

  function automatic logic [BITS-1:0] c2v(input logic [MW-1:0] m, input logic s);
    logic [MW-1:0] mp;
    mp = (m > Off) ? (m - Off) : '0;
    return s ? -{1'b0, mp} : {1'b0, mp};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      k_q     <= '0;
      j_q     <= '0;
      last_q  <= '0;
      sgn_q   <= '0;
      out_q   <= '0;
      olast_q <= 1'b0;
      for (int l = 0; l < Z; l++) begin
        min1_q[l] <= MaxMag;
        min2_q[l] <= MaxMag;
        idx_q[l]  <= '0;
      end
      for (int c = 0; c < DEG_MAX; c++) smem_q[c] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      last_q  <= last_d;
      sgn_q   <= sgn_d;
      out_q   <= out_d;
      olast_q <= olast_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      smem_q  <= smem_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic [MW-1:0] mag;
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    last_d  = last_q;
    sgn_d   = sgn_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    smem_d  = smem_q;
    mag     = '0;
    unique case (state_q)
      StAcc: begin
        if (in_valid) begin
          for (int l = 0; l < Z; l++) begin
            mag = mag_of(in[l]);
            // Strict compares: on a tie the earlier column keeps min1.
            if (mag < min1_q[l]) begin
              min2_d[l] = min1_q[l];
              min1_d[l] = mag;
              idx_d[l]  = k_q;
            end else if (mag < min2_q[l]) begin
              min2_d[l] = mag;
            end
            sgn_d[l]         = sgn_q[l] ^ in[l][BITS-1];
            smem_d[k_q][l]   = in[l][BITS-1];
          end
          k_d = k_q + KW'(1);
          if (in_last || (k_q == KLast)) begin
            state_d = StEmit;
            last_d  = k_q;
            k_d     = '0;
            j_d     = '0;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (j_q == last_q) begin
            state_d = StAcc;
            j_d     = '0;
            k_d     = '0;
            sgn_d   = '0;
            for (int l = 0; l < Z; l++) begin
              min1_d[l] = MaxMag;
              min2_d[l] = MaxMag;
            end
          end else begin
            j_d = j_q + KW'(1);
          end
        end
      end
      default: state_d = StAcc;
    endcase
  end

  // Outputs. out/out_last are registered from the next-state view so the
  // first C2V vector is ready the cycle after the closing accept and holds
  // steady through a stall.
  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StEmit);
    out       = out_q;
    out_last  = olast_q;
    out_d     = '0;
    olast_d   = 1'b0;
    if (state_d == StEmit) begin
      olast_d = (j_d == last_d);
      for (int l = 0; l < Z; l++) begin
        out_d[l] = c2v((j_d == idx_d[l]) ? min2_d[l] : min1_d[l],
                       sgn_d[l] ^ smem_d[j_d][l]);
      end
    end
  end

endmodule

// File: tb/tb_cnu_minsum.sv
module tb_cnu_minsum;

  localparam int BITS    = 8;
  localparam int Z       = 7;
  localparam int DEG_MAX = 8;

  typedef logic [Z-1:0][BITS-1:0] vec_t;
  typedef struct packed {
    vec_t v;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  vec_t din = '0;

  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  vec_t out_a, out_b;

  always #5 clk = ~clk;

  cnu_minsum #(.BITS(BITS), .Z(Z), .DEG_MAX(DEG_MAX), .OFFSET(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_last(in_last), .in(din), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_last(out_last_a), .out(out_a)
  );

  cnu_minsum #(.BITS(BITS), .Z(Z), .DEG_MAX(DEG_MAX), .OFFSET(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .in(din), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .out(out_b)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   row_len;
  int   row_buf [DEG_MAX][Z];

  task automatic check(input string tag, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic cmp_vec(input string tag, input vec_t got, input logic got_last,
                         input exp_t e);
    for (int l = 0; l < Z; l++)
      check($sformatf("%s_lane%0d", tag, l), int'($signed(got[l])), int'($signed(e.v[l])));
    check($sformatf("%s_last", tag), int'(got_last), int'(e.last));
  endtask

  function automatic int rval();
    logic [7:0] b;
    b = 8'($urandom);
    case ($urandom % 8)
      0: return -128;
      1: return 0;
      2: return 127;
      default: return int'($signed(b));
    endcase
  endfunction

  // Independent model: each output is the min magnitude over the other
  // columns, signed by the parity of the other columns' signs.
  task automatic push_exp();
    exp_t e;
    int   m, s, v, mag, off;
    for (int o = 0; o < 2; o++) begin
      off = (o == 0) ? 0 : 2;
      for (int j = 0; j < row_len; j++) begin
        e.v    = '0;
        e.last = (j == row_len - 1);
        for (int l = 0; l < Z; l++) begin
          m = 127;
          s = 0;
          for (int i = 0; i < row_len; i++) begin
            if (i != j) begin
              v   = row_buf[i][l];
              mag = (v < 0) ? ((v == -128) ? 127 : -v) : v;
              if (mag < m) m = mag;
              if (v < 0) s ^= 1;
            end
          end
          m = (m > off) ? m - off : 0;
          e.v[l] = BITS'(s ? -m : m);
        end
        if (o == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  task automatic fill_random(input int len);
    row_len = len;
    for (int k = 0; k < DEG_MAX; k++)
      for (int l = 0; l < Z; l++) row_buf[k][l] = rval();
  endtask

  // Called at posedge+1; returns at posedge+1 after the final accept.
  task automatic send_row(input bit last_flag);
    bit ok;
    for (int k = 0; k < row_len; k++) begin
      for (int l = 0; l < Z; l++) din[l] = BITS'(row_buf[k][l]);
      in_valid = 1'b1;
      in_last  = last_flag && (k == row_len - 1);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        ok = in_ready_a;
        @(posedge clk);
        #1;
      end
      if (!ok) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    push_exp();
    check("valid_rise", int'(out_valid_a), 1);
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 500 && (qa.size() != 0 || out_valid_a); c++) begin
      if (rnd) out_ready = 1'($urandom % 2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("drain_left", qa.size() + qb.size(), 0);
    check("idle_in_ready", int'(in_ready_a), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready_a), 1);
    check({tag, "_out_valid"}, int'(out_valid_a), 0);
    check({tag, "_out_last"}, int'(out_last_a), 0);
    for (int l = 0; l < Z; l++) check($sformatf("%s_out%0d", tag, l), int'(out_a[l]), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_ab", int'(out_valid_b), int'(out_valid_a));
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) check("unexpected_out_a", 1, 0);
        else begin
          ea = qa.pop_front();
          cmp_vec("a", out_a, out_last_a, ea);
        end
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) check("unexpected_out_b", 1, 0);
        else begin
          eb = qb.pop_front();
          cmp_vec("b", out_b, out_last_b, eb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-accumulation discards the partial row
    for (int l = 0; l < Z; l++) din[l] = 8'sd1;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      din = ~din;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(2);
    row_buf[0][0] = 50;
    row_buf[1][0] = -60;
    send_row(1'b1);
    drain(1'b0);

    // Basic row: every lane gets 5, -2, 7, 3
    row_len = 4;
    for (int l = 0; l < Z; l++) begin
      row_buf[0][l] = 5;
      row_buf[1][l] = -2;
      row_buf[2][l] = 7;
      row_buf[3][l] = 3;
    end
    send_row(1'b1);
    drain(1'b0);

    // Tie and saturation on lane 1
    fill_random(3);
    row_buf[0][1] = -128;
    row_buf[1][1] = 4;
    row_buf[2][1] = -4;
    send_row(1'b1);
    drain(1'b0);

    // Offset behaviour on lane 0 (dut_b has OFFSET=2)
    fill_random(3);
    row_buf[0][0] = 1;
    row_buf[1][0] = 6;
    row_buf[2][0] = -9;
    send_row(1'b1);
    drain(1'b0);

    // Degree 1 with backpressure
    fill_random(1);
    row_buf[0][0] = 10;
    out_ready = 1'b0;
    send_row(1'b1);
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", int'(out_valid_a), 1);
      check("stall_a0", int'($signed(out_a[0])), 127);
      check("stall_b0", int'($signed(out_b[0])), 125);
      check("stall_in_ready", int'(in_ready_a), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("deg1_in_ready", int'(in_ready_a), 1);
    drain(1'b0);

    // Forced end at DEG_MAX; a 9th vector is refused during EMIT
    fill_random(DEG_MAX);
    send_row(1'b0);
    for (int l = 0; l < Z; l++) din[l] = 8'sd9;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("emit_in_ready", int'(in_ready_a), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain(1'b0);

    // Random rows with random backpressure
    for (int r = 0; r < 20; r++) begin
      fill_random(1 + int'($urandom % DEG_MAX));
      send_row((row_len < DEG_MAX) ? 1'b1 : 1'($urandom % 2));
      drain(1'b1);
    end

    // Reset during EMIT drops the remaining outputs
    fill_random(3);
    out_ready = 1'b0;
    send_row(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("emitrst");
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    fill_random(2);
    send_row(1'b1);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
